// File: rtl/student_tlul_socket_pkg.sv
// rtl/student_tlul_socket_pkg.sv - address decode and sizing helpers for the 1:N socket
package student_tlul_socket_pkg;

  localparam int unsigned MAX_DEV  = 16;
  localparam int unsigned IDX_W    = 5;
  localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;

  // Width of a counter that must hold 0..max_out inclusive.
  function automatic int unsigned cnt_w(input int unsigned max_out);
    return $clog2(max_out + 1);
  endfunction

  // Lowest matching device index wins; no match returns num (the error responder).
  function automatic logic [IDX_W-1:0] dev_decode(
    input logic [31:0]              addr,
    input logic [MAX_DEV-1:0][31:0] base,
    input logic [MAX_DEV-1:0][31:0] mask,
    input int unsigned              num
  );
    logic [IDX_W-1:0] idx;
    idx = IDX_W'(num);
    for (int i = MAX_DEV - 1; i >= 0; i--) begin
      if ((i < int'(num)) && ((addr & ~mask[i]) == base[i])) begin
        idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/tlul_pkg.sv
// rtl/tlul_pkg.sv - TL-UL channel types and opcodes shared by the socket and its devices
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/student_tlul_err_resp.sv
// rtl/student_tlul_err_resp.sv - single-entry TL-UL responder that answers every request with an error
module student_tlul_err_resp
  import tlul_pkg::*;
  import student_tlul_socket_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_ni,
  input  tl_h2d_t tl_i,
  output tl_d2h_t tl_o
);

  typedef enum logic {ErrIdle, ErrResp} err_state_e;

  err_state_e  state_q;
  logic [7:0]  source_q;
  logic [1:0]  size_q;
  tl_d_op_e    opcode_q;
  logic        unused_fields;

  assign unused_fields = ^{tl_i.a_param, tl_i.a_address, tl_i.a_mask, tl_i.a_data};

  // Capture one request, then hold the error response until the host takes it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ErrIdle;
      source_q <= '0;
      size_q   <= '0;
      opcode_q <= AccessAck;
    end else begin
      case (state_q)
        ErrIdle: begin
          if (tl_i.a_valid) begin
            state_q  <= ErrResp;
            source_q <= tl_i.a_source;
            size_q   <= tl_i.a_size;
            opcode_q <= (tl_i.a_opcode == Get) ? AccessAckData : AccessAck;
          end
        end
        default: begin
          if (tl_i.d_ready) begin
            state_q <= ErrIdle;
          end
        end
      endcase
    end
  end

  // Response fields come straight from the captured request.
  always_comb begin
    tl_o          = '0;
    tl_o.a_ready  = (state_q == ErrIdle);
    tl_o.d_valid  = (state_q == ErrResp);
    tl_o.d_opcode = opcode_q;
    tl_o.d_size   = size_q;
    tl_o.d_source = source_q;
    tl_o.d_data   = ERR_DATA;
    tl_o.d_error  = 1'b1;
  end

endmodule

// File: rtl/student_tlul_socket_1n.sv
// rtl/student_tlul_socket_1n.sv - 1:N TL-UL socket with base/mask decode, in-order responses, error responder; STUDENT_TLUL_SOCKET_AREG_EN adds an A-channel skid buffer
module student_tlul_socket_1n
  import tlul_pkg::*;
  import student_tlul_socket_pkg::*;
#(
  parameter int unsigned              NUM             = 4,
  parameter int unsigned              MAX_OUTSTANDING = 2,
  parameter logic [NUM-1:0][31:0]     ADDR_BASE       = {32'h1000_3000, 32'h1000_2000,
                                                         32'h1000_1000, 32'h1000_0000},
  parameter logic [NUM-1:0][31:0]     ADDR_MASK       = {NUM{32'h0000_0FFF}}
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  tl_h2d_t tl_host_i,
  output tl_d2h_t tl_host_o,
  output tl_h2d_t tl_device_o [NUM],
  input  tl_d2h_t tl_device_i [NUM],
  output logic    busy_o
);

  localparam int unsigned      CNT_W   = cnt_w(MAX_OUTSTANDING);
  localparam logic [IDX_W-1:0] ERR_IDX = IDX_W'(NUM);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [MAX_DEV-1:0][31:0] base_pad, mask_pad;
  tl_h2d_t          req;
  logic             req_ready, host_a_ready;
  logic [IDX_W-1:0] sel, dev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall, tgt_ready, a_fire, d_fire;
  tl_h2d_t          err_h2d;
  tl_d2h_t          err_d2h, rsp;

`ifdef STUDENT_TLUL_SOCKET_AREG_EN
  tl_h2d_t    buf_q [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] fill_q;
  logic       push, pop;

  assign host_a_ready = (fill_q != 2'd2);
  assign push         = tl_host_i.a_valid && host_a_ready;
  assign pop          = req.a_valid && req_ready;

  // Head of the skid buffer feeds the decode; d_ready bypasses the buffer.
  always_comb begin
    req         = buf_q[rd_ptr_q];
    req.a_valid = (fill_q != 2'd0);
    req.d_ready = tl_host_i.d_ready;
  end

  // Two-entry FIFO so host a_ready depends only on fullness.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      fill_q   <= '0;
    end else begin
      if (push) begin
        buf_q[wr_ptr_q] <= tl_host_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      fill_q <= fill_q + {1'b0, push} - {1'b0, pop};
    end
  end
`else
  assign req          = tl_host_i;
  assign host_a_ready = req_ready;
`endif

  // Widen the per-device windows to the fixed size the decode helper takes.
  always_comb begin
    base_pad = '0;
    mask_pad = '0;
    for (int i = 0; i < int'(NUM); i++) begin
      base_pad[i] = ADDR_BASE[i];
      mask_pad[i] = ADDR_MASK[i];
    end
  end

  assign sel       = dev_decode(req.a_address, base_pad, mask_pad, NUM);
  assign stall     = (cnt_q == CNT_MAX) || ((cnt_q != '0) && (sel != dev_q));
  assign req_ready = !stall && tgt_ready;
  assign a_fire    = req.a_valid && req_ready;
  assign d_fire    = rsp.d_valid && tl_host_i.d_ready;
  assign busy_o    = (cnt_q != '0);

  // Route A to the decoded target; only the in-flight target sees d_ready.
  always_comb begin
    tgt_ready       = (sel == ERR_IDX) ? err_d2h.a_ready : 1'b0;
    err_h2d         = req;
    err_h2d.a_valid = req.a_valid && !stall && (sel == ERR_IDX);
    err_h2d.d_ready = tl_host_i.d_ready && (cnt_q != '0) && (dev_q == ERR_IDX);
    for (int i = 0; i < int'(NUM); i++) begin
      tl_device_o[i]         = req;
      tl_device_o[i].a_valid = req.a_valid && !stall && (sel == IDX_W'(i));
      tl_device_o[i].d_ready = tl_host_i.d_ready && (cnt_q != '0) && (dev_q == IDX_W'(i));
      if (sel == IDX_W'(i)) begin
        tgt_ready = tl_device_i[i].a_ready;
      end
    end
  end

  // Return the in-flight target's D channel; quiet when nothing is outstanding.
  always_comb begin
    rsp = '0;
    if (cnt_q != '0) begin
      if (dev_q == ERR_IDX) begin
        rsp = err_d2h;
      end
      for (int i = 0; i < int'(NUM); i++) begin
        if (dev_q == IDX_W'(i)) begin
          rsp = tl_device_i[i];
        end
      end
    end
    tl_host_o         = rsp;
    tl_host_o.a_ready = host_a_ready;
  end

  // Outstanding count moves by A fires up and D fires down.
  always_comb begin
    cnt_d = cnt_q;
    case ({a_fire, d_fire})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Target index is relatched only when the in-flight set is (or becomes) empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      dev_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (a_fire && ((cnt_q == '0) || ((cnt_q == CNT_W'(1)) && d_fire))) begin
        dev_q <= sel;
      end
    end
  end

  student_tlul_err_resp u_err_resp (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tl_i   (err_h2d),
    .tl_o   (err_d2h)
  );

endmodule

// File: doc/student_tlul_socket_1n.md
Name: student_tlul_socket_1n

Overview:
Parametrised successor to the peripheral TL-UL mux: one TL-UL host port fanned out to NUM device ports. Routing uses a per-device base/mask address decode instead of fixed select logic. It tracks up to MAX_OUTSTANDING in-flight requests and keeps responses in request order. Unmapped addresses are answered by an internal error responder, so an unmapped access can never hang the bus. It sits between the student top's peripheral port and its devices (rlight, irq_ctrl, future blocks).

Parameters:
- NUM, 4, number of device ports (1..16)
- MAX_OUTSTANDING, 2, maximum in-flight requests (1..15)
- ADDR_BASE, {32'h1000_3000, 32'h1000_2000, 32'h1000_1000, 32'h1000_0000}, device i base address, logic [NUM-1:0][31:0]
- ADDR_MASK, 32'h0000_0FFF per device, don't-care address bits for device i

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- tl_host_i  in  tlul_pkg::tl_h2d_t  request from upstream host
- tl_host_o  out  tlul_pkg::tl_d2h_t  response to upstream host
- tl_device_o  out  tlul_pkg::tl_h2d_t [NUM]  requests to devices
- tl_device_i  in  tlul_pkg::tl_d2h_t [NUM]  responses from devices
- busy_o  out  1  high while outstanding count is nonzero

Behaviour:
- Decode: device i matches when (a_address & ~ADDR_MASK[i]) == ADDR_BASE[i]. If several match, the lowest index wins. No match selects the error responder, index ERR_IDX = NUM.
- Outstanding state:
  - out_cnt_q: width clog2(MAX_OUTSTANDING+1).
  - dev_q: index of the target currently in flight.
- Host a_ready is combinational and is 0 when any of these holds:
  - out_cnt_q == MAX_OUTSTANDING;
  - out_cnt_q != 0 and the decoded index != dev_q (ordering stall; no cross-device reordering);
  - the selected target's a_ready is 0.
- A-channel forwarding: all fields of tl_host_i are passed to tl_device_o[sel]. a_valid is forced to 0 on every non-selected port and on every port while the request is stalled. d_ready is driven only to the dev_q port.
- D-channel: tl_host_o is the d_* fields of the dev_q target. When out_cnt_q == 0, d_valid is 0 and all other fields are 0.
- Counting:
  - A fire (valid & ready) increments out_cnt_q.
  - A D fire (host d_valid & d_ready) decrements it.
  - Both in the same cycle leave the count unchanged.
  - dev_q loads sel on an A fire when out_cnt_q == 0 or when the count would otherwise drop to 0 in the same cycle.
- Error responder:
  - Single entry. Its a_ready = !pending.
  - On an accepted request it captures a_source, a_size and a_opcode.
  - On the next cycle it asserts d_valid with:
    - d_error=1, d_data=32'hFFFF_FFFF, d_sink=0;
    - d_opcode=AccessAckData (1) for Get (4), AccessAck (0) for PutFullData (0) and PutPartialData (1);
    - d_source and d_size echoed from the request.
  - d_valid holds until d_ready. Back-to-back error requests are therefore accepted at most every 2 cycles.
- Latency: zero added cycles on A and on D; the path is purely combinational through the socket.
- Reset values: out_cnt_q=0, dev_q=0, error responder idle, busy_o=0, all device a_valid=0, host d_valid=0.
- Reset mid-operation clears all state immediately. In-flight responses arriving after reset are dropped, since d_ready is 0 while out_cnt_q == 0.
- A d_valid from a device that is not dev_q is ignored; it is never forwarded.

Optional Feature:
- Macro: STUDENT_TLUL_SOCKET_AREG_EN.
- When defined: a 2-entry skid buffer on the host A channel before the decode.
  - Adds 1 cycle of A latency.
  - Host a_ready depends only on buffer fullness, which breaks the combinational ready path.
  - Outstanding and ordering rules apply at the buffer output.
- When undefined: the A channel is fully combinational as described above.

Decomposition:
- Package student_tlul_socket_pkg holds:
  - function dev_decode(addr, base, mask) returning the index;
  - localparam helpers for count width;
  - ERR_DATA = 32'hFFFF_FFFF.
- TL-UL opcodes come from tlul_pkg.
- One sub-module: student_tlul_err_resp (the single-entry error responder). Also instantiated by future sockets.

Test Plan:
- Put 0x1234_5678 to 0x1000_1004 -> only tl_device_o[1].a_valid rises; AccessAck is returned with d_error=0; out_cnt returns to 0.
- Get at 0x2000_0000 (unmapped), a_source=3, size=2 -> next cycle host gets d_valid, AccessAckData, d_error=1, d_data=FFFF_FFFF, d_source=3.
- Two Gets to device 0 with device 0 withholding D -> both accepted; a 3rd Get is stalled (a_ready=0); after two D fires, responses arrive in order and busy_o falls.
- Get to device 2 while a device 0 request is outstanding -> a_ready=0 until the device 0 response fires; then device 2 is accepted the same or the next cycle.
- Simultaneous A fire and D fire with out_cnt=1 to the same device -> out_cnt stays 1, no bubble.
- Assert rst_ni low mid-transaction with out_cnt=2 -> out_cnt=0, host d_valid=0; a late device d_valid is not forwarded.
